// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding a round-robin arbiter that
// drives one registered common-data-bus broadcast per cycle.
package cdb_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [5:0]  pd_s;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        valid;
        logic [31:0] inst;
    } cdb_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_SRC-1:0] src_valid,
    output logic [NUM_SRC-1:0] src_ready,
    input  cdb_t [NUM_SRC-1:0] src_data,
    output cdb_t               cdb_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

    cdb_t               mem   [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0]      head  [NUM_SRC];
    logic [AW-1:0]      tail  [NUM_SRC];
    logic [CW-1:0]      count [NUM_SRC];
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      winner;
    logic               grant;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    cdb_t               win_data;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        return PW'((int'(base) + k) % NUM_SRC);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = count[i] < CW'(FIFO_DEPTH);
        end
        push = src_valid & src_ready & {NUM_SRC{~flush}};
    end

    // Scan downward so the closest non-empty source after rr_ptr wins last.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (count[rr_idx(rr_ptr, k)] != '0) begin
                grant  = 1'b1;
                winner = rr_idx(rr_ptr, k);
            end
        end
        pop      = grant ? NUM_SRC'(1) << winner : '0;
        win_data = mem[winner][head[winner]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            rr_ptr  <= '0;
            cdb_out <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            rr_ptr        <= '0;
            cdb_out.valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) tail[i] <= tail[i] + 1'b1;
                if (pop[i]) head[i] <= head[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (grant) begin
                cdb_out       <= win_data;
                cdb_out.valid <= 1'b1;
                rr_ptr        <= winner == PW'(NUM_SRC - 1) ? '0 : winner + 1'b1;
            end else begin
                cdb_out.valid <= 1'b0;
            end
        end
    end

    // Storage needs no reset: an entry is only read once its count covers it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) mem[i][tail[i]] <= src_data[i];
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors, directed corner sequences and a randomized
// run checked every cycle against a queue-based model of the CDB arbiter.
module tb_cdb_arbiter;
    import cdb_pkg::*;
    localparam int N = 3;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [N-1:0] src_valid = '0;
    logic [N-1:0] src_ready;
    cdb_t [N-1:0] src_data = '0;
    cdb_t         cdb_out;

    int           tests = 0;
    int           fails = 0;
    cdb_t         mq [N][$];
    int           rr = 0;
    cdb_t         exp_o = '0;
    logic [N-1:0] xf;
    logic [31:0]  got [$];

    typedef struct {
        logic [N-1:0]       v;
        logic               fl;
        logic [N-1:0][31:0] rv;
        logic               ev;
        logic [31:0]        erv;
        logic [N-1:0]       erdy;
    } vec_t;
    vec_t tbl [18];

    cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid),
        .src_ready(src_ready), .src_data(src_data), .cdb_out(cdb_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic cdb_t mk(input int rob, input int pd, input int rd, input logic [31:0] v, input logic [31:0] ins);
        cdb_t c;
        c = '0;
        c.rob_idx = 6'(rob);
        c.pd_s = 6'(pd);
        c.rd_s = 5'(rd);
        c.rd_v = v;
        c.inst = ins;
        return c;
    endfunction

    function automatic cdb_t rnd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[$bits(cdb_t)-1:0];
    endfunction

    function automatic vec_t vec(input logic [N-1:0] v, input logic fl, input logic [N-1:0][31:0] rv,
                                 input logic ev, input logic [31:0] erv, input logic [N-1:0] erdy);
        vec_t t;
        t.v = v; t.fl = fl; t.rv = rv; t.ev = ev; t.erv = erv; t.erdy = erdy;
        return t;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = mq[i].size() < D;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        rr = 0;
        exp_o = '0;
    endfunction

    // One clock edge of the abstract machine: grant from the oldest queue
    // contents, then append the accepted results.
    function automatic void model_step();
        int w;
        xf = src_valid & model_ready() & ~{N{flush}};
        if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            rr = 0;
            exp_o.valid = 1'b0;
            return;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && mq[(rr + k) % N].size() > 0) w = (rr + k) % N;
        end
        if (w >= 0) begin
            exp_o = mq[w].pop_front();
            exp_o.valid = 1'b1;
            rr = (w + 1) % N;
        end else begin
            exp_o.valid = 1'b0;
        end
        for (int i = 0; i < N; i++) if (xf[i]) mq[i].push_back(src_data[i]);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("cdb_out", cdb_out, exp_o);
        check("src_ready", src_ready, model_ready());
    endtask

    initial begin
        cdb_t d;
        cdb_t e;
        int n1;
        bit saw_full;
        tbl[0]  = vec(3'b111, 0, {32'h30, 32'h20, 32'h10}, 0, 32'h0,  3'b111);
        tbl[1]  = vec(3'b001, 0, {32'h0,  32'h0,  32'h40}, 1, 32'h10, 3'b111);
        tbl[2]  = vec(3'b000, 0, '0,                        1, 32'h20, 3'b111);
        tbl[3]  = vec(3'b000, 0, '0,                        1, 32'h30, 3'b111);
        tbl[4]  = vec(3'b000, 0, '0,                        1, 32'h40, 3'b111);
        tbl[5]  = vec(3'b000, 0, '0,                        0, 32'h40, 3'b111);
        tbl[6]  = vec(3'b111, 0, {32'h3,  32'h2,  32'h1},  0, 32'h40, 3'b111);
        tbl[7]  = vec(3'b111, 0, {32'h6,  32'h5,  32'h4},  1, 32'h2,  3'b010);
        tbl[8]  = vec(3'b010, 0, {32'h0,  32'h7,  32'h0},  1, 32'h3,  3'b100);
        tbl[9]  = vec(3'b100, 0, {32'h8,  32'h0,  32'h0},  1, 32'h1,  3'b001);
        tbl[10] = vec(3'b111, 1, {32'h9,  32'h9,  32'h9},  0, 32'h1,  3'b111);
        tbl[11] = vec(3'b000, 0, '0,                        0, 32'h1,  3'b111);
        tbl[12] = vec(3'b000, 0, '0,                        0, 32'h1,  3'b111);
        tbl[13] = vec(3'b111, 0, {32'hC,  32'hB,  32'hA},  0, 32'h1,  3'b111);
        tbl[14] = vec(3'b000, 0, '0,                        1, 32'hA,  3'b111);
        tbl[15] = vec(3'b000, 0, '0,                        1, 32'hB,  3'b111);
        tbl[16] = vec(3'b000, 0, '0,                        1, 32'hC,  3'b111);
        tbl[17] = vec(3'b000, 0, '0,                        0, 32'hC,  3'b111);

        repeat (2) @(posedge clk);
        #1;
        check("reset_cdb_out", cdb_out, '0);
        check("reset_ready", src_ready, 3'b111);
        rst = 1'b0;
        model_reset();

        // Round-robin order and flush behaviour from a table
        for (int k = 0; k < 18; k++) begin
            src_valid = tbl[k].v;
            flush = tbl[k].fl;
            for (int i = 0; i < N; i++) src_data[i] = mk(0, 0, 0, tbl[k].rv[i], 0);
            tick();
            check("tbl_valid", cdb_out.valid, tbl[k].ev);
            check("tbl_rd_v", cdb_out.rd_v, tbl[k].erv);
            check("tbl_ready", src_ready, tbl[k].erdy);
        end
        src_valid = '0;
        flush = 1'b0;

        // Single result with every field populated and the input valid bit low
        repeat (2) tick();
        d = mk(3, 12, 5, 32'hDEADBEEF, 32'h12345678);
        src_data[0] = d;
        src_valid = 3'b001;
        tick();
        src_valid = '0;
        check("single_c1_valid", cdb_out.valid, 0);
        tick();
        e = d;
        e.valid = 1'b1;
        check("single_out", cdb_out, e);
        tick();
        check("single_drop", cdb_out.valid, 0);

        // Backpressure on src 1 while srcs 0 and 2 stay busy
        n1 = 0;
        saw_full = 0;
        got.delete();
        for (int c = 0; c < 40; c++) begin
            if (c < 20) begin
                for (int i = 0; i < N; i += 2) begin
                    if (!src_valid[i]) begin
                        src_valid[i] = 1'b1;
                        src_data[i] = rnd();
                        src_data[i].inst = 32'(100 + i);
                    end
                end
            end
            if (n1 < 4) begin
                src_valid[1] = 1'b1;
                src_data[1] = mk(0, 0, 0, 32'(n1 + 1), 1);
            end
            d.inst = 32'(model_ready());
            if (src_valid[1] && !d.inst[1]) saw_full = 1;
            tick();
            if (xf[1]) n1++;
            src_valid &= ~xf;
            if (cdb_out.valid && cdb_out.inst == 1) got.push_back(cdb_out.rd_v);
        end
        check("bp_ready_low", saw_full, 1);
        check("bp_count", got.size(), 4);
        for (int k = 0; k < 4; k++) check("bp_order", got.size() > k ? got[k] : 32'hFFFFFFFF, k + 1);

        // Ten back-to-back results through src 2 wrap its pointers
        src_valid = '0;
        repeat (5) tick();
        for (int i = 0; i < 12; i++) begin
            src_valid = i < 10 ? 3'b100 : 3'b000;
            src_data[2] = mk(0, 0, 0, 32'(i), 2);
            tick();
            check("wrap_ready", src_ready[2], 1);
            if (i >= 1 && i <= 10) begin
                check("wrap_valid", cdb_out.valid, 1);
                check("wrap_rd_v", cdb_out.rd_v, i - 1);
            end
        end
        src_valid = '0;

        // Asynchronous reset while a broadcast is on the bus
        src_data[0] = mk(1, 2, 3, 32'h55, 7);
        src_valid = 3'b001;
        tick();
        src_valid = '0;
        tick();
        check("ar_pre_valid", cdb_out.valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_cdb_out", cdb_out, '0);
        check("ar_ready", src_ready, 3'b111);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        src_data[0] = mk(4, 5, 6, 32'h66, 8);
        src_valid = 3'b001;
        tick();
        src_valid = '0;
        tick();
        check("ar_post_valid", cdb_out.valid, 1);
        check("ar_post_rd_v", cdb_out.rd_v, 32'h66);

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] && $urandom_range(0, 99) < 60) begin
                    src_valid[i] = 1'b1;
                    src_data[i] = rnd();
                end
            end
            flush = $urandom_range(0, 99) < 4;
            tick();
            src_valid &= ~(xf | {N{flush}});
        end
        flush = 1'b0;
        src_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-side transmitter for the common data bus (CDB). The add, multiply and divide functional units each hand a completed result to this block over a valid/ready handshake. Each source has a small FIFO. A round-robin arbiter drives exactly one registered `cdb_t` broadcast per cycle to the reservation stations, ROB and physical register file. Flush drops all in-flight results on a branch mispredict.

## Interface
**Parameters**
- NUM_SRC, 3, number of result sources; index 0 = add, 1 = multiply, 2 = divide.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥ 2.

**Ports**
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- flush  input  1  synchronous squash of all buffered and outgoing results.
- src_valid  input  NUM_SRC  per-source result valid.
- src_ready  output  NUM_SRC  per-source FIFO can accept.
- src_data  input  NUM_SRC × cdb_t  per-source result (rob_idx[5:0], pd_s[5:0], rd_s[4:0], rd_v[31:0], valid, inst[31:0]); the embedded valid bit is ignored.
- cdb_out  output  cdb_t  registered broadcast; cdb_out.valid qualifies all other fields.

## Operation
**Handshake**
- A transfer occurs on source i in a cycle where src_valid[i] and src_ready[i] are both high and flush is low.
- The result is written into FIFO i at that rising edge.
- src_valid[i] must stay high, with src_data[i] stable, until the transfer.

**Ready**
- src_ready[i] = (count[i] < FIFO_DEPTH).
- Ready is driven purely from the registered count. A pop in the same cycle does not free a slot early.

**Arbitration**
- Runs every cycle over the FIFO heads where count[i] > 0.
- Priority is round-robin, starting at rr_ptr and ascending with wrap.
- The winner's head is popped and registered into cdb_out with valid = 1.
- After a grant, rr_ptr ← (winner + 1) mod NUM_SRC. With no grant, rr_ptr holds.
- With no candidate, cdb_out.valid ← 0 and the other fields hold their previous values.

**FIFO**
- Circular buffer with head and tail pointers that wrap modulo FIFO_DEPTH, plus a count of width clog2(FIFO_DEPTH) + 1.
- A push and a pop on the same FIFO in one cycle leave count unchanged. The entry is written at tail and read from head.
- Entries leave each FIFO in the order they entered.
- Results from different sources may be reordered relative to each other.

**Field handling**
- All cdb_t fields pass through unmodified, except cdb_out.valid, which the arbiter generates.
- rd_s = 0 results are broadcast normally. Consumers ignore them.

**Flush** (synchronous; wins over every other event)
- All counts, heads and tails go to 0; rr_ptr goes to 0; cdb_out.valid goes to 0.
- Transfers presented in the flush cycle are dropped.
- The pop that would have happened in the flush cycle is discarded.

**Reset** (asynchronous, at any time, including mid-transfer)
- Same effect as flush.
- All cdb_out fields go to 0.
- src_ready goes to all-ones, since every count is 0.

## Timing
- Reset values:
  - cdb_out = '0.
  - src_ready = '1.
  - rr_ptr = 0; all counts and pointers = 0.
- Minimum latency from a transfer to its broadcast:
  - Transfer in cycle c; the entry is written at the end of c.
  - The entry is the head in c+1, is granted, and is registered at the end of c+1.
  - cdb_out.valid = 1 during c+2.
- Each broadcast is valid for exactly one cycle. There is no backpressure from the CDB.
- Throughput: one result per cycle total, and one transfer per source per cycle.
- A full FIFO (count = FIFO_DEPTH) drops src_ready[i] the cycle after the filling transfer. Ready reasserts the cycle after a pop.
- Worst-case wait for the head of a non-empty FIFO: NUM_SRC − 1 cycles before it is granted.

## Test plan
- **Single result:** after reset, src 0 transfer in cycle 5 with rob_idx = 3, pd_s = 12, rd_s = 5, rd_v = 0xDEADBEEF → cdb_out.valid = 1 in cycle 7 with identical fields, and valid = 0 in cycle 8.
- **Round-robin:** all three sources transfer in the same cycle c with rd_v = 0x10, 0x20, 0x30 → broadcasts of 0x10, 0x20, 0x30 in cycles c+2, c+3, c+4. A new src 0 result arriving at c+1 is broadcast at c+5, after the src 2 result.
- **Full/backpressure:** src 1 holds valid for 4 consecutive cycles with rd_v = 1, 2, 3, 4 while srcs 0 and 2 are continuously busy.
  - src_ready[1] = 0 for the cycle(s) when count = 2.
  - Exactly 4 broadcasts occur from src 1, in the order 1, 2, 3, 4.
  - No duplicate or lost result.
- **Flush:**
  - Fill all FIFOs (6 entries), assert flush for one cycle → cdb_out.valid = 0 the next cycle and stays 0, all src_ready = 1, rr_ptr = 0.
  - A transfer presented during the flush cycle is never broadcast.
- **Async reset mid-stream:** assert rst between clock edges while cdb_out.valid = 1 → cdb_out = 0 immediately, without waiting for an edge. After deassert, a transfer in cycle r+1 is broadcast in cycle r+3.
- **Wrap-around:** stream 10 back-to-back results through src 2 only (rd_v = 0..9) → broadcasts 0..9 in order, one per cycle, starting 2 cycles after the first transfer. src_ready[2] stays 1 throughout.
